// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU control path: opcodes, state
// encodings and small opcode-class helpers used by the sequencer decode.
package cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_ANDI  = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_FAULT  = 3'd7;

    // Every opcode above STORE is a conditional branch.
    function automatic logic is_branch(input logic [3:0] op);
        return op > OP_STORE;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Adder is used by ADD/ADDI and by the load/store address calculation.
    function automatic logic op_adds(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || is_mem(op);
    endfunction

    function automatic logic op_ands(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_ANDI);
    endfunction

    function automatic logic op_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || is_mem(op);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; expired_o flags the last permitted wait cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] Limit = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr_i) begin
            wait_cnt_d = 8'd0;
        end else if (en_i) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired_o = (wait_cnt_q == Limit);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with datapath strobes
// and a sticky fault on data-memory timeout.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       cmp_true,
    output logic       ir_write,
    output logic       pc_write,
    output logic       dataMemRead,
    output logic       dataMemWrite,
    output logic       regWrite,
    output logic       immediate,
    output logic       ALUand,
    output logic       ALUadd,
    output logic       comparator,
    output logic       PCselect,
    output logic       instr_retired,
    output logic       fault,
    output logic [2:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op_q;
    logic [3:0] op_d;
    logic       in_mem;
    logic       timer_expired;

    assign in_mem = (state_q == ST_MEM);

    // Held clear outside MEM, so every MEM visit starts counting from zero.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clr_i     (!in_mem),
        .en_i      (in_mem && !dmem_ready),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d    = opcode;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_branch(op_q)) begin
                    state_d = ST_FETCH;
                end else if (is_mem(op_q)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // A completing access in the expiry cycle still wins over the fault.
                if (dmem_ready) begin
                    state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
                end else if (timer_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        dataMemRead   = 1'b0;
        dataMemWrite  = 1'b0;
        regWrite      = 1'b0;
        immediate     = 1'b0;
        ALUand        = 1'b0;
        ALUadd        = 1'b0;
        comparator    = 1'b0;
        PCselect      = 1'b0;
        instr_retired = 1'b0;
        fault         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_write = imem_ready;
            end
            ST_EXEC: begin
                if (is_branch(op_q)) begin
                    comparator    = 1'b1;
                    PCselect      = cmp_true;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                end else begin
                    ALUadd    = op_adds(op_q);
                    ALUand    = op_ands(op_q);
                    immediate = op_imm(op_q);
                end
            end
            ST_MEM: begin
                ALUadd       = 1'b1;
                immediate    = 1'b1;
                dataMemRead  = (op_q == OP_LOAD);
                dataMemWrite = (op_q == OP_STORE);
                if (op_q == OP_STORE && dmem_ready) begin
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                end
            end
            ST_WB: begin
                regWrite      = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                ALUadd        = op_adds(op_q);
                ALUand        = op_ands(op_q);
                immediate     = op_imm(op_q);
                // Keeps the write-data mux on the memory read path.
                dataMemRead   = (op_q == OP_LOAD);
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides everything, including the imem_ready passthrough.
        if (reset) begin
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            dataMemRead   = 1'b0;
            dataMemWrite  = 1'b0;
            regWrite      = 1'b0;
            immediate     = 1'b0;
            ALUand        = 1'b0;
            ALUadd        = 1'b0;
            comparator    = 1'b0;
            PCselect      = 1'b0;
            instr_retired = 1'b0;
            fault         = 1'b0;
        end
    end

    assign state = state_q;

endmodule
